// File: rtl/tag_alloc.sv
// -----------------------------------------------------------------------------
// tag_alloc: round-robin tag allocator for request-tracking tables
//
// Tracks which of W tags are in use and offers a free one each cycle. The
// offered tag comes from a circular first-zero search that starts just below
// the last granted tag. A free is committed at the same edge as a grant.
//
// Modules in this file:
//   s         - circular first-zero search primitive
//   tag_alloc - allocator top (busy vector, search pointer, in-use count)
//
// Optional build macro:
//   TAG_ALLOC_ERR_EN - adds err_o, a sticky flag. It sets on a free of a
//                      tag that is not allocated, or on a request while full.
//
// tag_alloc ports:
//   clk          in   clock
//   arst_n       in   asynchronous active-low reset
//   alloc_req_i  in   requester wants a tag this cycle
//   alloc_vld_o  out  a free tag is offered (== !full_o)
//   alloc_tag_o  out  offered tag, encoded (meaningful only with alloc_vld_o)
//   alloc_vec_o  out  offered tag, one-hot (zero when nothing is offered)
//   free_vld_i   in   release a tag this cycle
//   free_tag_i   in   tag being released
//   busy_o       out  registered busy vector
//   cnt_o        out  registered count of allocated tags, 0..W
//   full_o       out  every tag allocated
//   empty_o      out  no tag allocated
//   err_o        out  sticky illegal-use flag (TAG_ALLOC_ERR_EN only)
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// s: circular first-zero search
//
// Finds the first clear bit of x_i. The search visits pos_i-1, pos_i-2, ...,
// 0, W-1, ..., and ends at pos_i. As a result, pos_i itself is chosen only
// when it is the sole clear bit.
//   x_i      in   vector to search (set bit = occupied)
//   pos_i    in   search origin
//   y_o      out  one-hot of the bit found (zero if none)
//   y_enc_o  out  encoded index of the bit found (zero if none)
//   any_o    out  a clear bit exists
// -----------------------------------------------------------------------------
module s #(
    parameter  int unsigned W  = 32,
    localparam int unsigned TW = $clog2(W)
) (
    input  logic [W-1:0]  x_i,
    input  logic [TW-1:0] pos_i,
    output logic [W-1:0]  y_o,
    output logic [TW-1:0] y_enc_o,
    output logic          any_o
);

    logic [TW-1:0] idx;

    // Priority walk downward from pos_i. The last step wraps back to pos_i,
    // because TW'(W) truncates to zero.
    always_comb begin
        y_o     = '0;
        y_enc_o = '0;
        any_o   = 1'b0;
        idx     = '0;
        for (int unsigned k = 1; k <= W; k++) begin
            idx = pos_i - TW'(k);
            if (!any_o && !x_i[idx]) begin
                any_o     = 1'b1;
                y_enc_o   = idx;
                y_o[idx]  = 1'b1;
            end
        end
    end

endmodule

module tag_alloc #(
    parameter  int unsigned W  = 32,
    localparam int unsigned TW = $clog2(W)
) (
    input  logic          clk,
    input  logic          arst_n,
    input  logic          alloc_req_i,
    output logic          alloc_vld_o,
    output logic [TW-1:0] alloc_tag_o,
    output logic [W-1:0]  alloc_vec_o,
    input  logic          free_vld_i,
    input  logic [TW-1:0] free_tag_i,
    output logic [W-1:0]  busy_o,
    output logic [TW:0]   cnt_o,
    output logic          full_o,
    output logic          empty_o
`ifdef TAG_ALLOC_ERR_EN
    ,
    output logic          err_o
`endif
);

    localparam int unsigned CW = TW + 1;

    logic [W-1:0]  busy_r;
    logic [TW-1:0] ptr_r;
    logic [CW-1:0] cnt_r;

    logic [W-1:0]  busy_nxt;
    logic [TW-1:0] ptr_nxt;
    logic [CW-1:0] cnt_nxt;

    logic [W-1:0]  srch_vec;
    logic [TW-1:0] srch_tag;
    logic          srch_any;
    logic          alloc_fire;
    logic          free_fire;

    // Search runs only on registered state, so no input reaches an output.
    s #(.W(W)) u_srch (
        .x_i     (busy_r),
        .pos_i   (ptr_r),
        .y_o     (srch_vec),
        .y_enc_o (srch_tag),
        .any_o   (srch_any)
    );

    // Offer path
    assign alloc_vld_o = srch_any;
    assign alloc_tag_o = srch_tag;
    assign alloc_vec_o = srch_any ? srch_vec : '0;

    assign alloc_fire  = alloc_req_i & srch_any;
    assign free_fire   = free_vld_i & busy_r[free_tag_i];

    // Next state. A grant and a free never target the same tag: the grant
    // is taken from the clear bits and the free from the set bits.
    always_comb begin
        busy_nxt = busy_r;
        ptr_nxt  = ptr_r;
        cnt_nxt  = cnt_r;
        if (alloc_fire) begin
            busy_nxt = busy_nxt | srch_vec;
            ptr_nxt  = srch_tag;
        end
        if (free_fire) begin
            busy_nxt[free_tag_i] = 1'b0;
        end
        cnt_nxt = cnt_r + CW'(alloc_fire) - CW'(free_fire);
    end

    // State registers
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            busy_r <= '0;
            ptr_r  <= '0;
            cnt_r  <= '0;
        end else begin
            busy_r <= busy_nxt;
            ptr_r  <= ptr_nxt;
            cnt_r  <= cnt_nxt;
        end
    end

    assign busy_o  = busy_r;
    assign cnt_o   = cnt_r;
    assign full_o  = (cnt_r == CW'(W));
    assign empty_o = (cnt_r == '0);

`ifdef TAG_ALLOC_ERR_EN
    logic err_r;

    // Sticky misuse flag. It is cleared only by reset.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            err_r <= 1'b0;
        end else if ((free_vld_i & ~busy_r[free_tag_i]) | (alloc_req_i & full_o)) begin
            err_r <= 1'b1;
        end
    end

    assign err_o = err_r;
`endif

endmodule

// File: tb/tb_tag_alloc.sv
// -----------------------------------------------------------------------------
// tb_tag_alloc: directed bench for tag_alloc with W=8.
// A driver applies one vector per cycle and queues the outputs expected in
// that cycle. A monitor on the falling edge pops each entry and compares it
// with the DUT outputs.
// -----------------------------------------------------------------------------
module tb_tag_alloc;

    localparam int unsigned W  = 8;
    localparam int unsigned TW = 3;

    typedef struct {
        bit          rst;
        bit          req;
        bit          fv;
        int unsigned ft;
        bit          vld;
        int unsigned tag;
        int unsigned busy;
        int unsigned cnt;
        bit          err;
    } vec_t;

    logic          clk = 1'b0;
    logic          arst_n = 1'b0;
    logic          alloc_req_i = 1'b0;
    logic          alloc_vld_o;
    logic [TW-1:0] alloc_tag_o;
    logic [W-1:0]  alloc_vec_o;
    logic          free_vld_i = 1'b0;
    logic [TW-1:0] free_tag_i = '0;
    logic [W-1:0]  busy_o;
    logic [TW:0]   cnt_o;
    logic          full_o;
    logic          empty_o;
`ifdef TAG_ALLOC_ERR_EN
    logic          err_o;
`endif

    int   n_vec  = 0;
    int   n_miss = 0;
    vec_t vecs[$];
    vec_t sb[$];

    tag_alloc #(.W(W)) dut (
        .clk         (clk),
        .arst_n      (arst_n),
        .alloc_req_i (alloc_req_i),
        .alloc_vld_o (alloc_vld_o),
        .alloc_tag_o (alloc_tag_o),
        .alloc_vec_o (alloc_vec_o),
        .free_vld_i  (free_vld_i),
        .free_tag_i  (free_tag_i),
        .busy_o      (busy_o),
        .cnt_o       (cnt_o),
        .full_o      (full_o),
        .empty_o     (empty_o)
`ifdef TAG_ALLOC_ERR_EN
        ,
        .err_o       (err_o)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int unsigned idx,
                       input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s vec%0d: got %0h expected %0h", nm, idx, act, exp);
        end
    endtask

    task automatic add(input bit rst, input bit req, input bit fv, input int unsigned ft,
                       input bit vld, input int unsigned tag, input int unsigned busy,
                       input int unsigned cnt, input bit err);
        vec_t v;
        v.rst = rst; v.req = req; v.fv = fv; v.ft = ft;
        v.vld = vld; v.tag = tag; v.busy = busy; v.cnt = cnt; v.err = err;
        vecs.push_back(v);
    endtask

    task automatic add_fill();
        add(0,1,0,0, 1,7,'h00,0,0);
        add(0,1,0,0, 1,6,'h80,1,0);
        add(0,1,0,0, 1,5,'hC0,2,0);
        add(0,1,0,0, 1,4,'hE0,3,0);
        add(0,1,0,0, 1,3,'hF0,4,0);
        add(0,1,0,0, 1,2,'hF8,5,0);
        add(0,1,0,0, 1,1,'hFC,6,0);
        add(0,1,0,0, 1,0,'hFE,7,0);
    endtask

    // Monitor: one expected entry per driven cycle
    int unsigned mon_idx = 0;
    always @(negedge clk) begin
        if (sb.size() != 0) begin
            vec_t        e;
            logic [W-1:0] ev;
            e  = sb.pop_front();
            ev = '0;
            if (e.vld) ev[e.tag] = 1'b1;
            chk("alloc_vld", mon_idx, 32'(alloc_vld_o), 32'(e.vld));
            if (e.vld) chk("alloc_tag", mon_idx, 32'(alloc_tag_o), e.tag);
            chk("alloc_vec", mon_idx, 32'(alloc_vec_o), 32'(ev));
            chk("busy", mon_idx, 32'(busy_o), e.busy);
            chk("cnt", mon_idx, 32'(cnt_o), e.cnt);
            chk("full", mon_idx, 32'(full_o), 32'(e.cnt == W));
            chk("empty", mon_idx, 32'(empty_o), 32'(e.cnt == 0));
            chk("cnt_popcount", mon_idx, 32'(cnt_o), 32'($countones(busy_o)));
`ifdef TAG_ALLOC_ERR_EN
            chk("err", mon_idx, 32'(err_o), 32'(e.err));
`endif
            mon_idx++;
        end
    end

    // Driver
    initial begin
        // Fill from reset: grants 7 down to 0
        add_fill();
        add(0,0,0,0, 0,0,'hFF,8,0);   // full, nothing offered
        add(0,0,1,3, 0,0,'hFF,8,0);   // free 3
        add(0,1,0,0, 1,3,'hF7,7,0);   // only tag 3 is free; take it
        add(0,0,1,6, 0,0,'hFF,8,0);   // free 6
        add(0,1,0,0, 1,6,'hBF,7,0);   // grant 6, ptr -> 6
        add(0,0,1,0, 0,0,'hFF,8,0);   // free 0
        add(0,0,1,3, 1,0,'hFE,7,0);   // free 3
        add(0,1,1,1, 1,3,'hF6,6,0);   // grant 3 and free 1 together
        add(0,0,1,7, 1,1,'hFC,6,0);   // cnt unchanged, ptr 3; free 7
        add(0,1,0,0, 1,1,'h7C,5,0);   // grant 1, ptr -> 1
        add(0,1,0,0, 1,0,'h7E,6,0);   // grant 0
        add(0,1,0,0, 1,7,'h7F,7,0);   // wrap: grant 7
        add(0,0,1,5, 0,0,'hFF,8,0);   // free 5
        add(0,0,1,5, 1,5,'hDF,7,0);   // free 5 again: ignored
        add(0,0,1,4, 1,5,'hDF,7,1);   // free 4
        add(0,0,1,6, 1,5,'hCF,6,1);   // free 6
        add(0,0,0,0, 1,6,'h8F,5,1);   // cnt 5
        add(1,0,0,0, 1,7,'h00,0,0);   // async reset mid-stream
        add_fill();
        add(0,1,0,0, 0,0,'hFF,8,0);   // request while full: no effect
        add(0,0,0,0, 0,0,'hFF,8,1);
        add(0,1,0,0, 0,0,'hFF,8,1);

        repeat (3) @(posedge clk);
        foreach (vecs[i]) begin
            @(posedge clk);
            #1;
            arst_n      = !vecs[i].rst;
            alloc_req_i = vecs[i].req;
            free_vld_i  = vecs[i].fv;
            free_tag_i  = TW'(vecs[i].ft);
            sb.push_back(vecs[i]);
        end
        @(posedge clk);
        #1;
        alloc_req_i = 1'b0;
        free_vld_i  = 1'b0;

        for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
        n_vec++;
        if (sb.size() != 0) begin
            n_miss++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
